// File: rtl/rvvi_trace_pkg.sv
// Shared types and widths for the RVVI retirement trace driver.
package rvvi_trace_pkg;

    localparam int XLEN    = 64;
    localparam int ILEN    = 32;
    localparam int ORDER_W = 64;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic [31:0]     x_wb;
        logic [XLEN-1:0] wdata;
    } trace_entry_t;

endpackage

// File: rtl/rvvi_trace_driver_if.sv
// Retirement beat bus from the core probe into the trace driver.
interface rvvi_trace_driver_if
    import rvvi_trace_pkg::*;
#(
    parameter int RETIRE = 2
);
    localparam int CW = $clog2(RETIRE + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [CW-1:0]          in_count;
    logic [RETIRE*XLEN-1:0] in_pc;
    logic [RETIRE*ILEN-1:0] in_insn;
    logic [RETIRE-1:0]      in_trap;
    logic [RETIRE-1:0]      in_rd_wen;
    logic [RETIRE*5-1:0]    in_rd;
    logic [RETIRE*XLEN-1:0] in_rd_wdata;

    modport master (
        output in_valid, in_count, in_pc, in_insn,
        output in_trap, in_rd_wen, in_rd, in_rd_wdata,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_count, in_pc, in_insn,
        input  in_trap, in_rd_wen, in_rd, in_rd_wdata,
        output in_ready
    );

endinterface

// File: rtl/rvvi_trace_fifo.sv
// Circular buffer: up to RETIRE writes per cycle, one read, exposes occupancy.
module rvvi_trace_fifo
    import rvvi_trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int RETIRE = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(RETIRE + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [CW-1:0] wr_count,
    input  trace_entry_t wr_data [RETIRE],
    input  logic         rd_en,
    output trace_entry_t rd_data,
    output logic [AW:0]  count,
    output logic         empty
);
    localparam int PW = AW + 1;

    trace_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(wr_count);
            if (rd_en && !empty) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Slot i lands at wr_ptr+i; the AW-bit index wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RETIRE; i++) begin
            if (wr_en && i < int'(wr_count))
                mem[wr_ptr[AW-1:0] + AW'(i)] <= wr_data[i];
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/rvvi_trace_driver.sv
// Buffers multi-retire beats and replays them one per clock on RVVI slot [0][0].
module rvvi_trace_driver
    import rvvi_trace_pkg::*;
#(
    parameter int RETIRE = 2,
    parameter int DEPTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    rvvi_trace_driver_if.slave in_bus,
    input  logic               out_halt,
    output logic               out_valid,
    output logic [ORDER_W-1:0] out_order,
    output logic [XLEN-1:0]    out_pc,
    output logic [ILEN-1:0]    out_insn,
    output logic               out_trap,
    output logic [31:0]        out_x_wb,
    output logic [XLEN-1:0]    out_x_wdata,
    output logic               overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RETIRE + 1);
    localparam int PW = AW + 1;

    trace_entry_t  slot [RETIRE];
    trace_entry_t  head;
    trace_entry_t  out_q;
    logic [AW:0]   count;
    logic [AW:0]   cnt_next;
    logic [CW-1:0] wr_n;
    logic          empty;
    logic          ready_q;
    logic          accept;
    logic          count_ok;
    logic          wr_en;
    logic          pop;

    always_comb begin
        for (int i = 0; i < RETIRE; i++) begin
            logic [4:0] rd;
            rd = in_bus.in_rd[i*5 +: 5];
            slot[i].pc    = in_bus.in_pc[i*XLEN +: XLEN];
            slot[i].insn  = in_bus.in_insn[i*ILEN +: ILEN];
            slot[i].trap  = in_bus.in_trap[i];
            slot[i].wdata = in_bus.in_rd_wdata[i*XLEN +: XLEN];
            slot[i].x_wb  = (in_bus.in_rd_wen[i] && rd != 5'd0)
                          ? (32'(1) << rd) : 32'd0;
        end
    end

    assign accept   = in_bus.in_valid && ready_q;
    assign count_ok = (in_bus.in_count != '0)
                   && (in_bus.in_count <= CW'(RETIRE));
    assign wr_en    = accept && count_ok;
    assign wr_n     = wr_en ? in_bus.in_count : '0;
    assign pop      = !out_halt && !empty;
    assign cnt_next = count + PW'(wr_n) - PW'(pop);

    rvvi_trace_fifo #(
        .DEPTH  (DEPTH),
        .RETIRE (RETIRE)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_count (in_bus.in_count),
        .wr_data  (slot),
        .rd_en    (pop),
        .rd_data  (head),
        .count    (count),
        .empty    (empty)
    );

    // Ready looks at post-update occupancy so a whole beat always fits.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b1;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_order <= '0;
            out_q     <= '0;
        end else begin
            ready_q <= (cnt_next <= PW'(DEPTH - RETIRE));
            if (accept && !count_ok) overflow <= 1'b1;
            if (out_halt) begin
                out_valid <= 1'b0;
            end else if (!empty) begin
                out_q     <= head;
                out_valid <= 1'b1;
                out_order <= out_order + ORDER_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign in_bus.in_ready = ready_q;
    assign out_pc      = out_q.pc;
    assign out_insn    = out_q.insn;
    assign out_trap    = out_q.trap;
    assign out_x_wb    = out_q.x_wb;
    assign out_x_wdata = out_q.wdata;

endmodule

// File: tb/tb_rvvi_trace_driver.sv
// Directed bench for rvvi_trace_driver; an entry accepted at edge N
// appears on the outputs after edge N+1 (registered FIFO read).
module tb_rvvi_trace_driver;
    import rvvi_trace_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               out_halt;
    logic               out_valid;
    logic [ORDER_W-1:0] out_order;
    logic [XLEN-1:0]    out_pc;
    logic [ILEN-1:0]    out_insn;
    logic               out_trap;
    logic [31:0]        out_x_wb;
    logic [XLEN-1:0]    out_x_wdata;
    logic               overflow;

    int vectors = 0;
    int miscompares = 0;

    rvvi_trace_driver_if #(.RETIRE(2)) bus ();

    rvvi_trace_driver #(.RETIRE(2), .DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_bus      (bus),
        .out_halt    (out_halt),
        .out_valid   (out_valid),
        .out_order   (out_order),
        .out_pc      (out_pc),
        .out_insn    (out_insn),
        .out_trap    (out_trap),
        .out_x_wb    (out_x_wb),
        .out_x_wdata (out_x_wdata),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int s, input logic [63:0] pc,
                            input logic [31:0] insn, input logic trap,
                            input logic wen, input logic [4:0] rd,
                            input logic [63:0] wdata);
        bus.in_pc[s*64 +: 64]       = pc;
        bus.in_insn[s*32 +: 32]     = insn;
        bus.in_trap[s]              = trap;
        bus.in_rd_wen[s]            = wen;
        bus.in_rd[s*5 +: 5]         = rd;
        bus.in_rd_wdata[s*64 +: 64] = wdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        out_halt     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_count = 2'd0;
        set_slot(0, 64'h0, 32'h0, 1'b0, 1'b0, 5'd0, 64'h0);
        set_slot(1, 64'h0, 32'h0, 1'b0, 1'b0, 5'd0, 64'h0);
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_order", out_order, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_xwb", 64'(out_x_wb), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);

        // single retirement
        set_slot(0, 64'h8000_0000, 32'h0050_0093, 1'b0, 1'b1, 5'd1, 64'd5);
        bus.in_count = 2'd1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t1_lat_valid", 64'(out_valid), 64'd0);
        step();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_order", out_order, 64'd1);
        chk("t1_pc", out_pc, 64'h8000_0000);
        chk("t1_insn", 64'(out_insn), 64'h0050_0093);
        chk("t1_xwb", 64'(out_x_wb), 64'h2);
        chk("t1_wdata", out_x_wdata, 64'd5);
        step();
        chk("t1_idle", 64'(out_valid), 64'd0);

        // two-wide beat
        do_reset();
        set_slot(0, 64'h100, 32'h13, 1'b0, 1'b0, 5'd0, 64'd0);
        set_slot(1, 64'h104, 32'h13, 1'b0, 1'b0, 5'd0, 64'd0);
        bus.in_count = 2'd2;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("t2_v0", 64'(out_valid), 64'd1);
        chk("t2_pc0", out_pc, 64'h100);
        chk("t2_ord0", out_order, 64'd1);
        step();
        chk("t2_v1", 64'(out_valid), 64'd1);
        chk("t2_pc1", out_pc, 64'h104);
        chk("t2_ord1", out_order, 64'd2);
        step();
        chk("t2_idle", 64'(out_valid), 64'd0);

        // halt while filling: ready drops after 7 single beats
        do_reset();
        out_halt     = 1'b1;
        bus.in_count = 2'd1;
        for (int k = 0; k < 7; k++) begin
            set_slot(0, 64'h200 + 64'(4*k), 32'h13, 1'b0, 1'b0, 5'd0, 64'd0);
            bus.in_valid = 1'b1;
            chk("t3_ready_fill", 64'(bus.in_ready), 64'd1);
            step();
        end
        set_slot(0, 64'h21C, 32'h13, 1'b0, 1'b0, 5'd0, 64'd0);
        chk("t3_ready_full", 64'(bus.in_ready), 64'd0);
        step();
        step();
        chk("t3_halt_valid", 64'(out_valid), 64'd0);
        chk("t3_halt_pc", out_pc, 64'd0);
        chk("t3_stall", 64'(bus.in_ready), 64'd0);
        out_halt = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 1) bus.in_valid = 1'b0;
            chk("t3_valid", 64'(out_valid), 64'd1);
            chk("t3_pc", out_pc, 64'h200 + 64'(4*k));
            chk("t3_order", out_order, 64'(k + 1));
        end
        step();
        chk("t3_idle", 64'(out_valid), 64'd0);

        // x0 write with trap, then rd=31
        do_reset();
        set_slot(0, 64'h300, 32'h0000_0073, 1'b1, 1'b1, 5'd0, 64'hDEAD);
        bus.in_count = 2'd1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("t4_trap", 64'(out_trap), 64'd1);
        chk("t4_xwb0", 64'(out_x_wb), 64'd0);
        chk("t4_wdata", out_x_wdata, 64'hDEAD);
        chk("t4_order", out_order, 64'd1);
        set_slot(0, 64'h304, 32'h13, 1'b0, 1'b1, 5'd31, 64'h7);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("t4_valid2", 64'(out_valid), 64'd1);
        chk("t4_order2", out_order, 64'd2);
        chk("t4_xwb31", 64'(out_x_wb), 64'h8000_0000);
        chk("t4_trap2", 64'(out_trap), 64'd0);

        // bad in_count values
        do_reset();
        bus.in_count = 2'd0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t5_ovf", 64'(overflow), 64'd1);
        step();
        step();
        chk("t5_sticky", 64'(overflow), 64'd1);
        chk("t5_novalid", 64'(out_valid), 64'd0);
        do_reset();
        chk("t5_rst_ovf", 64'(overflow), 64'd0);
        bus.in_count = 2'd3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t5_ovf3", 64'(overflow), 64'd1);
        step();
        step();
        chk("t5_novalid3", 64'(out_valid), 64'd0);

        // reset with 4 buffered entries
        do_reset();
        out_halt     = 1'b1;
        bus.in_count = 2'd2;
        bus.in_valid = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        out_halt     = 1'b0;
        reset        = 1'b1;
        step();
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        chk("t6_ready", 64'(bus.in_ready), 64'd1);
        step();
        chk("t6_empty", 64'(out_valid), 64'd0);
        set_slot(0, 64'h500, 32'h13, 1'b0, 1'b0, 5'd0, 64'd0);
        bus.in_count = 2'd1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("t6_valid", 64'(out_valid), 64'd1);
        chk("t6_pc", out_pc, 64'h500);
        chk("t6_order", out_order, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
